// File: rtl/cdc_c2g_rx.sv
// Global-domain receiver for the count-to-global CDC path: detect synchronizer,
// edge capture of the held data buses, and a FWFT event FIFO.
// Optional dropped-event counter: define CDC_C2G_RX_DROP_CNT_EN.
module cdc_c2g_rx #(
   parameter int DATASIZE    = 16,
   parameter int COUNTSIZE   = 32,
   parameter int SYNC_STAGES = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                          g_clk,
   input  logic                          g_rst,
   input  logic                          c_detect_c2g,
   input  logic [DATASIZE-1:0]           c_diff_c2g,
   input  logic [2*COUNTSIZE-1:0]        c_diff_count_c2g,
   input  logic                          g_rd_en,
   output logic                          g_valid,
   output logic [DATASIZE-1:0]           g_diff,
   output logic [2*COUNTSIZE-1:0]        g_diff_count,
   output logic [$clog2(FIFO_DEPTH):0]   g_level,
   output logic                          g_overflow,
   output logic [15:0]                   g_drop_count
);

   localparam int AW = $clog2(FIFO_DEPTH) + 1;
   localparam int EW = DATASIZE + 2*COUNTSIZE;
   localparam logic [2:0] FILL_N = 3'(SYNC_STAGES);

   logic [SYNC_STAGES-1:0] sync;
   logic                   s_prev;
   logic                   armed;
   logic [2:0]             fill_cnt;
   logic                   fill_done;
   logic                   sync_last;
   logic                   rise;

   logic [EW-1:0]          mem [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;
   logic [AW-1:0]          wr_ptr_nxt;
   logic [AW-1:0]          rd_ptr_nxt;
   logic                   full;
   logic                   empty;
   logic                   rd_do;
   logic                   wr_do;
   logic                   drop;
   logic [EW-1:0]          wr_data;
   logic [EW-1:0]          head_nxt;

   assign sync_last = sync[SYNC_STAGES-1];
   assign fill_done = (fill_cnt == FILL_N);
   assign rise      = sync_last & ~s_prev & armed;
   assign wr_data   = {c_diff_c2g, c_diff_count_c2g};

   // Reset zeros in the chain are not real samples of the strobe, so arming
   // waits until the chain has been refilled; a strobe held high across reset
   // release therefore never arms the edge detector.
   always_ff @(posedge g_clk or posedge g_rst) begin
      if (g_rst) begin
         sync     <= '0;
         s_prev   <= 1'b0;
         armed    <= 1'b0;
         fill_cnt <= '0;
      end else begin
         sync   <= {sync[SYNC_STAGES-2:0], c_detect_c2g};
         s_prev <= sync_last;
         if (!fill_done)
            fill_cnt <= fill_cnt + 3'd1;
         if (fill_done && !sync_last)
            armed <= 1'b1;
      end
   end

   always_comb begin
      full       = (wr_ptr[AW-1] != rd_ptr[AW-1]) &&
                   (wr_ptr[AW-2:0] == rd_ptr[AW-2:0]);
      empty      = (wr_ptr == rd_ptr);
      rd_do      = g_rd_en & ~empty;
      wr_do      = rise & (~full | rd_do);
      drop       = rise & full & ~rd_do;
      rd_ptr_nxt = rd_ptr + AW'(rd_do);
      wr_ptr_nxt = wr_ptr + AW'(wr_do);
      // The entry being written becomes the head when the FIFO is (or is
      // about to be) empty; bypass it so the registered head is never stale.
      if (wr_do && (rd_ptr_nxt == wr_ptr))
         head_nxt = wr_data;
      else
         head_nxt = mem[rd_ptr_nxt[AW-2:0]];
   end

   always_ff @(posedge g_clk) begin
      if (wr_do)
         mem[wr_ptr[AW-2:0]] <= wr_data;
   end

   always_ff @(posedge g_clk or posedge g_rst) begin
      if (g_rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         g_valid      <= 1'b0;
         g_diff       <= '0;
         g_diff_count <= '0;
         g_level      <= '0;
         g_overflow   <= 1'b0;
      end else begin
         wr_ptr                 <= wr_ptr_nxt;
         rd_ptr                 <= rd_ptr_nxt;
         g_valid                <= (wr_ptr_nxt != rd_ptr_nxt);
         g_level                <= wr_ptr_nxt - rd_ptr_nxt;
         {g_diff, g_diff_count} <= head_nxt;
         if (drop)
            g_overflow <= 1'b1;
      end
   end

`ifdef CDC_C2G_RX_DROP_CNT_EN
   always_ff @(posedge g_clk or posedge g_rst) begin
      if (g_rst)
         g_drop_count <= '0;
      else if (drop && (g_drop_count != 16'hFFFF))
         g_drop_count <= g_drop_count + 16'd1;
   end
`else
   assign g_drop_count = '0;
`endif

endmodule

// File: tb/tb_cdc_c2g_rx.sv
// Directed scoreboard bench for cdc_c2g_rx: latency, FIFO order, overflow,
// coincident read/write, empty pop, reset arming and asynchronous reset.
module tb_cdc_c2g_rx;

   typedef struct packed {
      logic [15:0] d;
      logic [63:0] c;
   } ent_t;

`ifdef CDC_C2G_RX_DROP_CNT_EN
   localparam logic [63:0] DROP1 = 64'd1;
`else
   localparam logic [63:0] DROP1 = 64'd0;
`endif

   logic        g_clk = 1'b0;
   logic        g_rst = 1'b1;
   logic        c_detect_c2g = 1'b0;
   logic [15:0] c_diff_c2g = '0;
   logic [63:0] c_diff_count_c2g = '0;
   logic        g_rd_en = 1'b0;
   logic        g_valid;
   logic [15:0] g_diff;
   logic [63:0] g_diff_count;
   logic [2:0]  g_level;
   logic        g_overflow;
   logic [15:0] g_drop_count;

   int   compares = 0;
   int   fails    = 0;
   ent_t sb[$];

   cdc_c2g_rx #(
      .DATASIZE(16), .COUNTSIZE(32), .SYNC_STAGES(2), .FIFO_DEPTH(4)
   ) dut (
      .g_clk(g_clk), .g_rst(g_rst),
      .c_detect_c2g(c_detect_c2g), .c_diff_c2g(c_diff_c2g),
      .c_diff_count_c2g(c_diff_count_c2g), .g_rd_en(g_rd_en),
      .g_valid(g_valid), .g_diff(g_diff), .g_diff_count(g_diff_count),
      .g_level(g_level), .g_overflow(g_overflow), .g_drop_count(g_drop_count)
   );

   always #5 g_clk = ~g_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compares++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Strobe high ~15 ns starting 2 ns after a rising edge: exactly one g_clk
   // edge (E0, 8 ns later) samples it high. Returns between E0 and E0+1.
   task automatic strobe(input logic [15:0] d, input logic [63:0] c, input bit keep);
      ent_t e;
      @(posedge g_clk);
      #2;
      c_diff_c2g       = d;
      c_diff_count_c2g = c;
      c_detect_c2g     = 1'b1;
      e = {d, c};
      if (keep) sb.push_back(e);
      #15 c_detect_c2g = 1'b0;
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge g_clk);
   endtask

   task automatic pop_chk(input string tag);
      ent_t e;
      @(negedge g_clk);
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      chk({tag, ".valid"}, 64'(g_valid), 64'd1);
      chk({tag, ".diff"}, 64'(g_diff), 64'(e.d));
      chk({tag, ".count"}, g_diff_count, e.c);
      g_rd_en = 1'b1;
      @(posedge g_clk);
      #1 g_rd_en = 1'b0;
   endtask

   task automatic level_chk(input string tag);
      @(negedge g_clk);
      chk({tag, ".level"}, 64'(g_level), 64'(sb.size()));
      chk({tag, ".valid"}, 64'(g_valid), 64'(sb.size() != 0));
   endtask

   task automatic reset_chk(input string tag);
      chk({tag, ".valid"}, 64'(g_valid), 64'd0);
      chk({tag, ".diff"}, 64'(g_diff), 64'd0);
      chk({tag, ".count"}, g_diff_count, 64'd0);
      chk({tag, ".level"}, 64'(g_level), 64'd0);
      chk({tag, ".ovf"}, 64'(g_overflow), 64'd0);
      chk({tag, ".dropcnt"}, 64'(g_drop_count), 64'd0);
   endtask

   initial begin
      ent_t e;
      // Reset state
      settle(3);
      @(negedge g_clk);
      reset_chk("rst");
      g_rst = 1'b0;
      settle(6);

      // Single event with latency check: low after E0+1, valid after E0+2
      strobe(16'hABCD, 64'h1234, 1'b1);
      @(posedge g_clk);
      #1 chk("lat.e1", 64'(g_valid), 64'd0);
      @(posedge g_clk);
      #1 chk("lat.e2", 64'(g_valid), 64'd1);
      chk("lat.diff", 64'(g_diff), 64'hABCD);
      chk("lat.count", g_diff_count, 64'h1234);
      pop_chk("single");
      level_chk("single.after");

      // Burst of 4 fills the FIFO, 5th is dropped
      for (int i = 0; i < 4; i++) begin
         strobe(16'h1000 + 16'(i), 64'hF000_0000_0000_0000 + 64'(i), 1'b1);
         settle(3);
      end
      level_chk("burst.full");
      strobe(16'hDEAD, 64'hBAD, 1'b0);
      settle(3);
      @(negedge g_clk);
      chk("drop.ovf", 64'(g_overflow), 64'd1);
      chk("drop.cnt", 64'(g_drop_count), DROP1);
      chk("drop.level", 64'(g_level), 64'd4);
      chk("drop.head", 64'(g_diff), 64'(sb[0].d));
      for (int i = 0; i < 4; i++) pop_chk("burst.drain");
      level_chk("burst.empty");
      chk("drop.sticky", 64'(g_overflow), 64'd1);

      // Full FIFO with 5th rise coinciding with a pop: no drop
      for (int i = 0; i < 4; i++) begin
         strobe(16'h2000 + 16'(i), 64'h55 + 64'(i), 1'b1);
         settle(3);
      end
      strobe(16'h2FFF, 64'h5A5A_5A5A_5A5A_5A5A, 1'b1);
      @(posedge g_clk);
      #1;
      e = sb.pop_front();
      chk("coinc.head", 64'(g_diff), 64'(e.d));
      g_rd_en = 1'b1;
      @(posedge g_clk);
      #1 g_rd_en = 1'b0;
      level_chk("coinc.full");
      chk("coinc.dropcnt", 64'(g_drop_count), DROP1);
      for (int i = 0; i < 4; i++) pop_chk("coinc.drain");
      level_chk("coinc.empty");

      // Pop while empty is ignored
      g_rd_en = 1'b1;
      settle(2);
      #1 g_rd_en = 1'b0;
      level_chk("emptypop");

      // Rise coinciding with a read while empty: write proceeds, read ignored
      strobe(16'h3333, 64'h3333_0000, 1'b1);
      @(posedge g_clk);
      #1 g_rd_en = 1'b1;
      @(posedge g_clk);
      #1 g_rd_en = 1'b0;
      level_chk("emptycoinc");
      pop_chk("emptycoinc");
      level_chk("emptycoinc.after");

      // Strobe held high across reset release is not captured
      @(negedge g_clk);
      g_rst = 1'b1;
      c_detect_c2g = 1'b1;
      settle(2);
      @(negedge g_clk);
      g_rst = 1'b0;
      settle(10);
      level_chk("heldhigh");
      c_detect_c2g = 1'b0;
      settle(6);
      strobe(16'h4444, 64'h4444_4444, 1'b1);
      settle(4);
      level_chk("heldhigh.one");
      pop_chk("heldhigh");
      level_chk("heldhigh.after");

      // Asynchronous reset with 3 entries queued
      for (int i = 0; i < 3; i++) begin
         strobe(16'h5000 + 16'(i), 64'h77 + 64'(i), 1'b1);
         settle(3);
      end
      level_chk("midrst.pre");
      @(negedge g_clk);
      #1 g_rst = 1'b1;
      #1 reset_chk("midrst");
      sb.delete();
      @(negedge g_clk);
      g_rst = 1'b0;
      settle(6);
      strobe(16'h6060, 64'h6060_6060_6060, 1'b1);
      settle(4);
      level_chk("postrst");
      pop_chk("postrst");
      level_chk("postrst.after");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
      $finish;
   end

endmodule

// File: doc/cdc_c2g_rx.md
# cdc_c2g_rx

Global-domain (g_clk, 100.8 MHz) receiving end of the count-to-global CDC path. It synchronizes the stretched detect strobe from the count domain (460 MHz) and detects its rising edge. On that edge it captures the held diff/diff_count bus, which has been stable since the strobe rose, and queues each event in a small first-word-fall-through FIFO for the RAM write logic.

## Interface
Parameters:
- DATASIZE, 16, width of diff word
- COUNTSIZE, 32, diff_count is 2*COUNTSIZE bits
- SYNC_STAGES, 2, flip-flops in detect synchronizer (legal 2..4)
- FIFO_DEPTH, 4, event entries (power of 2, 2..16)

Ports:
- g_clk  in  1  global-domain clock
- g_rst  in  1  asynchronous, active-high reset
- c_detect_c2g  in  1  stretched detect from count domain (asynchronous to g_clk)
- c_diff_c2g  in  DATASIZE  held diff (quasi-static while detect high)
- c_diff_count_c2g  in  2*COUNTSIZE  held diff_count
- g_rd_en  in  1  consumer pops head entry
- g_valid  out  1  FIFO non-empty; head data valid
- g_diff  out  DATASIZE  head entry diff
- g_diff_count  out  2*COUNTSIZE  head entry diff_count
- g_level  out  $clog2(FIFO_DEPTH)+1  entries held
- g_overflow  out  1  sticky: an event was dropped
- g_drop_count  out  16  dropped-event counter (see Configuration)

## Operation
- Synchronizer: shift register sync[0..SYNC_STAGES-1] samples c_detect_c2g each g_clk; an extra register s_prev holds the last stage delayed.
- Edge: rise = sync[last] & ~s_prev & armed.
- Arming: armed resets to 0. It sets on the first cycle where sync[last]==0. A strobe already high at reset release is therefore ignored, not captured.
- Capture: on rise, c_diff_c2g and c_diff_count_c2g are written directly into the FIFO tail.
  - The data buses are not synchronized. They are legal to sample because the sender holds them from the strobe's rise until the next event, at least 14 count clocks later.
- FIFO: FIFO_DEPTH entries with binary read/write pointers of width $clog2(FIFO_DEPTH)+1, wrapping naturally. full = pointer MSBs differ and the rest are equal. empty = pointers equal.
- Read: g_rd_en with g_valid high advances the read pointer. g_rd_en while empty is ignored, with no pointer change.
- Write when full:
  - Simultaneous rise and g_rd_en when full: both proceed; level stays FIFO_DEPTH.
  - Rise when full without g_rd_en: the event is dropped, g_overflow sets and holds until g_rst.
- Simultaneous rise and g_rd_en when empty: the write proceeds. The read is ignored, since g_valid was low.
- Outputs are registered. g_diff/g_diff_count show the head entry and are don't-care while g_valid is 0.

## Timing
- Reset values: sync chain 0, s_prev 0, armed 0, pointers 0, g_valid 0, g_diff 0, g_diff_count 0, g_level 0, g_overflow 0, g_drop_count 0.
- Latency: let edge E0 be the first g_clk edge that samples c_detect_c2g high. g_valid (and the head data) is high after edge E0+SYNC_STAGES. With SYNC_STAGES=2 this is 2 edges after E0, and the data is visible in the third cycle.
- g_level updates on the same edge as the write or pop.
- One event per strobe high period. The sender guarantees ≥7 count clocks high and ≥7 low (≈1.5 g_clk each), so every strobe is seen at least once.
- Reset mid-operation: asynchronous clear of everything; queued events are lost. Capture resumes only after armed sets again.

## Configuration
- Macro: CDC_C2G_RX_DROP_CNT_EN.
- Defined: g_drop_count increments on every dropped event and saturates at 16'hFFFF.
- Undefined: the counter logic is absent and g_drop_count is tied to 0. g_overflow behaves identically in both builds.

## Test plan
- Single event: diff=16'hABCD, count=64'h1234; 7-count-clock strobe → g_valid high 2 edges after E0, g_diff=ABCD, g_diff_count=0x1234. Pop → g_valid 0, g_level 0.
- Burst of 4 events, no reads → g_level=4, FIFO order preserved. A 5th event drops → g_overflow=1, g_drop_count=1 (macro on) or 0 (macro off). Heads unchanged.
- Full FIFO, 5th event's rise coincides with g_rd_en → no drop, g_level stays 4, new entry at tail.
- Pop with FIFO empty → no pointer change, g_level stays 0, g_valid stays 0.
- c_detect_c2g held high through reset release → no capture. After it goes low and pulses again → exactly one event.
- Assert g_rst with 3 entries queued → all outputs at reset values immediately (asynchronous). A subsequent event is captured normally.
